// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised synchronous up/down counter with parallel
// load, programmable reload/terminal value, wrap or one-shot mode and a
// registered terminal-count pulse.
//
// Optional feature macro: UPDOWN_COUNTER_PRESCALER_EN
//   defined   -> a step happens only once every PRESCALE qualifying edges
//   undefined -> every edge with enable=1 and done=0 is a step (PRESCALE unused)
//
// Interface timing: no valid/ready handshake. Every output is registered and
// valid on every cycle; inputs sampled at edge N are reflected after edge N.
// Priority at each edge: reset low > load > count step > hold.
module updown_counter_n #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}},
  parameter int                 PRESCALE    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] reload_value,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             done
);

  // A step may only be requested while the counter is not frozen by done.
  logic step_request;
  logic step_tick;

  assign step_request = enable && !done;

`ifdef UPDOWN_COUNTER_PRESCALER_EN
  // One extra bit of headroom keeps the width legal when PRESCALE is 1.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] prescale_q;

  assign step_tick = step_request && (prescale_q == PRE_LAST);

  // Prescaler: counts qualifying edges, restarts after each step, cleared by load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prescale_q <= '0;
    end else if (load) begin
      prescale_q <= '0;
    end else if (step_request) begin
      if (prescale_q == PRE_LAST) begin
        prescale_q <= '0;
      end else begin
        prescale_q <= prescale_q + 1'b1;
      end
    end
  end
`else
  assign step_tick = step_request;
`endif

  // Next-state decode for a single step: terminal detection and mode handling.
  logic [WIDTH-1:0] step_count;
  logic             step_tc;
  logic             step_done;
  logic             up_terminal;
  logic             down_terminal;

  assign up_terminal   = (count_out == reload_value);
  assign down_terminal = (count_out == '0);

  // Combinational step result; only applied when step_tick is high.
  always_comb begin
    step_count = count_out;
    step_tc    = 1'b0;
    step_done  = done;
    if (up_down) begin
      if (up_terminal) begin
        step_tc = 1'b1;
        if (one_shot) begin
          step_done = 1'b1;
        end else begin
          step_count = '0;
        end
      end else begin
        // Natural rollover from all-ones to zero is not a terminal event.
        step_count = count_out + 1'b1;
      end
    end else begin
      if (down_terminal) begin
        step_tc = 1'b1;
        if (one_shot) begin
          step_done = 1'b1;
        end else begin
          step_count = reload_value;
        end
      end else begin
        step_count = count_out - 1'b1;
      end
    end
  end

  // Main count register, terminal pulse and sticky one-shot flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_out <= RESET_VALUE;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else if (load) begin
      count_out <= load_value;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else if (step_tick) begin
      count_out <= step_count;
      tc        <= step_tc;
      done      <= step_done;
    end else begin
      tc        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed scenarios with literal expectations plus
// randomized traffic checked against a behavioural model, via an expected
// queue drained by an independent monitor.
module tb_updown_counter_n;

  localparam int W  = 8;
  localparam int PS = 4;
  localparam int EW = W + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         up_down = 1'b0;
  logic         one_shot = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] reload_value = '0;
  logic [W-1:0] count_out;
  logic         tc;
  logic         done;

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_count;
  bit m_tc;
  bit m_done;
  int m_pre;

  updown_counter_n #(
    .WIDTH       (W),
    .RESET_VALUE ({W{1'b1}}),
    .PRESCALE    (PS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .up_down      (up_down),
    .one_shot     (one_shot),
    .load         (load),
    .load_value   (load_value),
    .reload_value (reload_value),
    .count_out    (count_out),
    .tc           (tc),
    .done         (done)
  );

  // Clock generation
  always #5 clock = ~clock;

  // Reference model: one edge of the counter as described by its rules.
  task automatic model_edge(input bit rst, input bit ld, input bit en,
                            input bit ud, input bit os,
                            input int lv, input int rv);
    bit step;
    if (!rst) begin
      m_count = 255; m_tc = 0; m_done = 0; m_pre = 0;
    end else if (ld) begin
      m_count = lv; m_tc = 0; m_done = 0; m_pre = 0;
    end else begin
      m_tc = 0;
      step = en && !m_done;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
      if (step) begin
        if (m_pre == PS - 1) m_pre = 0;
        else begin m_pre = m_pre + 1; step = 0; end
      end
`endif
      if (step) begin
        if (ud) begin
          if (m_count == rv) begin
            m_tc = 1;
            if (os) m_done = 1; else m_count = 0;
          end else begin
            m_count = (m_count + 1) % 256;
          end
        end else begin
          if (m_count == 0) begin
            m_tc = 1;
            if (os) m_done = 1; else m_count = rv;
          end else begin
            m_count = m_count - 1;
          end
        end
      end
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge and queue the
  // expected outputs (literal values when chk=1, model values otherwise).
  task automatic drive(input bit rst, input bit ld, input bit en,
                       input bit ud, input bit os,
                       input logic [W-1:0] lv, input logic [W-1:0] rv,
                       input bit chk, input logic [W-1:0] ec,
                       input bit etc, input bit edone);
    logic [W-1:0] mc;
    @(negedge clock);
    reset = rst; load = ld; enable = en; up_down = ud; one_shot = os;
    load_value = lv; reload_value = rv;
    model_edge(rst, ld, en, ud, os, int'(lv), int'(rv));
    mc = W'(m_count);
    if (chk) exp_q.push_back({ec, etc, edone});
    else     exp_q.push_back({mc, m_tc, m_done});
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({count_out, tc, done} !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t count/tc/done got %h/%b/%b expected %h/%b/%b",
                   $time, count_out, tc, done, e[EW-1:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rv, lv;
    bit os, ud, en, ld, rst;
    int wait_cnt;

    // Reset scenario: random inputs while reset is low
    for (int i = 0; i < 2; i++)
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom), 1, 8'hFF, 0, 0);

`ifndef UPDOWN_COUNTER_PRESCALER_EN
    // Down wrap: load 3, reload 5
    drive(1, 1, 0, 0, 0, 8'd3, 8'd5, 1, 8'd3, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd2, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd1, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd5, 1, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd4, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 8'd5, 1, 8'd3, 0, 0);

    // Up one-shot: load FD, terminal FF
    drive(1, 1, 0, 1, 1, 8'hFD, 8'hFF, 1, 8'hFD, 0, 0);
    drive(1, 0, 1, 1, 1, 8'h00, 8'hFF, 1, 8'hFE, 0, 0);
    drive(1, 0, 1, 1, 1, 8'h00, 8'hFF, 1, 8'hFF, 0, 0);
    drive(1, 0, 1, 1, 1, 8'h00, 8'hFF, 1, 8'hFF, 1, 1);
    drive(1, 0, 1, 1, 1, 8'h00, 8'hFF, 1, 8'hFF, 0, 1);
    drive(1, 0, 1, 1, 0, 8'h00, 8'hFF, 1, 8'hFF, 0, 1);
    drive(1, 1, 0, 1, 1, 8'h00, 8'hFF, 1, 8'h00, 0, 0);

    // Up rollover without terminal
    drive(1, 1, 0, 1, 0, 8'hFE, 8'h10, 1, 8'hFE, 0, 0);
    drive(1, 0, 1, 1, 0, 8'h00, 8'h10, 1, 8'hFF, 0, 0);
    drive(1, 0, 1, 1, 0, 8'h00, 8'h10, 1, 8'h00, 0, 0);
    drive(1, 0, 1, 1, 0, 8'h00, 8'h10, 1, 8'h01, 0, 0);

    // reload_value = 0 in wrap mode, down: sits at 0 pulsing tc
    drive(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0);
    drive(1, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0);
    drive(1, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0);

    // Simultaneous events
    drive(1, 1, 1, 1, 0, 8'h42, 8'h10, 1, 8'h42, 0, 0);
    drive(0, 1, 1, 1, 0, 8'h42, 8'h10, 1, 8'hFF, 0, 0);
`else
    // Prescaled down count with enable toggling
    drive(1, 1, 0, 0, 0, 8'd10, 8'd20, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drive(1, 0, (i % 2) == 0, 0, 0, 8'd0, 8'd20, 0, 0, 0, 0);
`endif

    // Randomized traffic against the model
    rv = 8'd3; os = 0; ud = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) ud = 1'($urandom);
      if ($urandom_range(0, 63) == 0) os = 1'($urandom);
      if ($urandom_range(0, 99) == 0)
        case ($urandom_range(0, 4))
          0: rv = 8'd0;
          1: rv = 8'd1;
          2: rv = 8'd4;
          3: rv = 8'hFF;
          default: rv = W'($urandom);
        endcase
      case ($urandom_range(0, 3))
        0: lv = 8'd0;
        1: lv = rv - 8'd2;
        2: lv = 8'hFE;
        default: lv = W'($urandom);
      endcase
      drive(rst, ld, en, ud, os, lv, rv, 0, 0, 0, 0);
    end

    // Drain the scoreboard within a bounded number of cycles
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clock);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised synchronous up/down counter with parallel load, programmable terminal/reload value, selectable wrap (auto-reload) or one-shot mode, and a registered terminal-count pulse. It is the general-purpose counter for timer, timeout and event-count paths, replacing fixed-width free-running down counters. All outputs are registered, one clock domain.

## Interface

- `WIDTH`, 8: counter width in bits, ≥ 2.
- `RESET_VALUE`, {WIDTH{1'b1}}: value `count_out` takes at reset.
- `PRESCALE`, 4: enable cycles per count step, ≥ 1. Used only when `UPDOWN_COUNTER_PRESCALER_EN` is defined.

- `clock` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: count request, sampled every edge.
- `up_down` in 1: 1 = count up, 0 = count down.
- `one_shot` in 1: 0 = wrap/auto-reload mode, 1 = one-shot mode.
- `load` in 1: parallel load strobe.
- `load_value` in WIDTH: value loaded on `load`.
- `reload_value` in WIDTH: down-count reload value and up-count terminal value.
- `count_out` out WIDTH: current count.
- `tc` out 1: one-cycle terminal-count pulse.
- `done` out 1: sticky one-shot completion flag.

## Operation

- Priority at each rising edge: `reset` low > `load` > count step > hold.
- Reset (`reset`=0): `count_out`=RESET_VALUE, `tc`=0, `done`=0, prescaler=0.
- Load: `count_out`=`load_value`, `done`=0, `tc`=0, prescaler=0. `enable` is ignored that cycle.
- Step condition: `enable`=1, `done`=0, and a prescaler tick if compiled in.
- Down step: if `count_out`≠0, then `count_out`−1. If `count_out`=0 (terminal), `tc`=1 and:
  - wrap mode: `count_out`=`reload_value`.
  - one-shot mode: `count_out` holds 0 and `done`=1.
- Up step: if `count_out`≠`reload_value`, then `count_out`+1 modulo 2^WIDTH. A natural rollover from all-ones to 0 does not assert `tc`. If `count_out`=`reload_value` (terminal), `tc`=1 and:
  - wrap mode: `count_out`=0.
  - one-shot mode: `count_out` holds and `done`=1.
- `tc` is 0 on every edge that is not a terminal step.
- While `done`=1, the count is frozen and `enable` is ignored. Only `load` or reset clears `done`. Changing `one_shot` has no effect on `done`.
- `up_down`, `one_shot` and `reload_value` are sampled at each step. A change mid-count takes effect at the next step edge; there is no pipeline to flush.
- `reload_value`=0 in wrap mode:
  - down: the counter sits at 0 and pulses `tc` every step.
  - up: `tc` pulses every step.

## Timing

- Latency: one cycle. Inputs sampled at edge N are reflected in outputs after edge N.
- `tc` is high for exactly the one cycle following a terminal step edge. Back-to-back `tc` pulses are legal, e.g. for `reload_value`=0.
- `done` rises together with the final `tc` pulse.
- `load` and reset take effect on the same edge they are sampled. Reset mid-count discards all state, including the prescaler phase.
- No combinational input-to-output paths.

## Configuration

- `UPDOWN_COUNTER_PRESCALER_EN` defined:
  - a $clog2(PRESCALE)-bit prescaler counts edges with `enable`=1 and `done`=0;
  - a step occurs only when the prescaler equals PRESCALE−1, after which the prescaler returns to 0;
  - the prescaler is cleared by reset and `load`, and holds while `enable`=0;
  - with PRESCALE=1 this is identical to the undefined case.
- Undefined: no prescaler logic. Every edge with `enable`=1 and `done`=0 is a step, and `PRESCALE` is ignored.

## Test plan

All scenarios use WIDTH=8 and macro undefined unless noted.

- Reset: hold `reset`=0 for 2 edges with random inputs → `count_out`=8'hFF, `tc`=0, `done`=0.
- Down wrap: load 3, `reload_value`=5, `up_down`=0, `enable`=1 for 6 edges → `count_out` = 2,1,0,5,4,3; `tc` high only in the cycle `count_out` first shows 5.
- Up one-shot: load 8'hFD, `reload_value`=8'hFF, `one_shot`=1, `enable`=1 for 5 edges → FE, FF, then holds FF; `tc` is one pulse; `done`=1 thereafter. Then `load`=1 with `load_value`=0 → `count_out`=0, `done`=0.
- Up with no `tc` on rollover: `reload_value`=8'h10, load 8'hFE, count up 3 edges → FF, 00, 01; `tc` stays 0.
- Simultaneous events: `load`=1 with `enable`=1 → loaded value with no step. `reset`=0 with `load`=1 → 8'hFF.
- Prescaler (macro defined, PRESCALE=4): load 10, down, `enable` toggling 1/0 each cycle for 16 cycles → `count_out` 9 after the 4th enabled edge and 8 after the 8th.
